// File: rtl/eth_rx_frame_buffer.sv
// MAC RX frame buffer: stores frames speculatively and publishes them to the reader only on a good-FCS commit.
// Read data is registered one cycle after rd_pop; there is no backpressure to the MAC, so an overflowing frame is dropped.
module eth_rx_frame_buffer #(
  parameter int DEPTH      = 1024,
  parameter int MAX_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_start,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  output logic        rd_frame_ready,
  output logic [15:0] rd_frame_len,
  input  logic        rd_pop,
  output logic        rd_data_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  rd_bytes_valid,
  output logic        rd_last,
  output logic [31:0] perf_crc_drops,
  output logic [31:0] perf_ovf_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES);
  localparam int LW = FW + 1;

  typedef struct packed {
    logic [2:0]  bv;
    logic [31:0] dat;
  } rx_word_t;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  rx_word_t    mem [DEPTH];
  logic [15:0] lf_mem [MAX_FRAMES];

  state_t      state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
  logic [15:0] len_q, len_d, rd_cnt_q, rd_cnt_d;
  logic [31:0] crc_cnt_q, crc_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic        rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  rx_word_t    rd_word_q, rd_word_d;

  logic          wr_en, lf_push, lf_pop, buf_full, lf_full, lf_empty;
  logic [PW-1:0] used, new_ptr;
  logic [LW-1:0] lf_used;
  logic [15:0]   new_len, head_len, nwords;
  logic [16:0]   len_p3;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lf_wr_d      = lf_wr_q;
    lf_rd_d      = lf_rd_q;
    len_d        = len_q;
    rd_cnt_d     = rd_cnt_q;
    crc_cnt_d    = crc_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    rd_vld_d     = 1'b0;
    rd_last_d    = 1'b0;
    rd_word_d    = '0;
    wr_en        = 1'b0;
    lf_push      = 1'b0;
    lf_pop       = 1'b0;

    used     = wr_ptr_q - rd_ptr_q;
    buf_full = (used == PW'(DEPTH));
    lf_used  = lf_wr_q - lf_rd_q;
    lf_full  = (lf_used == LW'(MAX_FRAMES));
    lf_empty = (lf_used == '0);
    head_len = lf_mem[lf_rd_q[FW-1:0]];
    len_p3   = {1'b0, head_len} + 17'd3;
    nwords   = 16'(len_p3 >> 2);
    new_len  = len_q + (rx_data_valid ? {13'b0, rx_bytes_valid} : 16'd0);
    new_ptr  = wr_ptr_q + PW'(rx_data_valid);

    case (state_q)
      IDLE: begin
        if (rx_start) begin
          state_d  = RECV;
          wr_ptr_d = commit_ptr_q;
          len_d    = '0;
        end
      end
      RECV: begin
        if (rx_start) begin
          // Truncated frame: the new start reuses the uncommitted space.
          wr_ptr_d  = commit_ptr_q;
          len_d     = '0;
          ovf_cnt_d = ovf_cnt_q + 32'd1;
        end else if (rx_data_valid && buf_full) begin
          wr_ptr_d = commit_ptr_q;
          if (rx_commit || rx_drop) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
            state_d   = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else begin
          wr_en    = rx_data_valid;
          wr_ptr_d = new_ptr;
          len_d    = new_len;
          if (rx_commit) begin
            state_d = IDLE;
            if (new_len == '0) begin
              wr_ptr_d = commit_ptr_q;
            end else if (lf_full) begin
              wr_ptr_d  = commit_ptr_q;
              ovf_cnt_d = ovf_cnt_q + 32'd1;
            end else begin
              lf_push      = 1'b1;
              commit_ptr_d = new_ptr;
            end
          end else if (rx_drop) begin
            wr_ptr_d  = commit_ptr_q;
            crc_cnt_d = crc_cnt_q + 32'd1;
            state_d   = IDLE;
          end
        end
      end
      DISCARD: begin
        if (rx_start || rx_commit || rx_drop) begin
          wr_ptr_d  = commit_ptr_q;
          len_d     = '0;
          ovf_cnt_d = ovf_cnt_q + 32'd1;
          state_d   = rx_start ? RECV : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_pop && !lf_empty) begin
      rd_vld_d  = 1'b1;
      rd_word_d = mem[rd_ptr_q[AW-1:0]];
      rd_ptr_d  = rd_ptr_q + PW'(1);
      if (rd_cnt_q + 16'd1 == nwords) begin
        rd_last_d = 1'b1;
        rd_cnt_d  = '0;
        lf_pop    = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end

    lf_wr_d = lf_wr_q + LW'(lf_push);
    lf_rd_d = lf_rd_q + LW'(lf_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      lf_wr_q      <= '0;
      lf_rd_q      <= '0;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      crc_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lf_wr_q      <= lf_wr_d;
      lf_rd_q      <= lf_rd_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      crc_cnt_q    <= crc_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      rd_word_q    <= rd_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= '{bv: rx_bytes_valid, dat: rx_data};
    if (lf_push) lf_mem[lf_wr_q[FW-1:0]] <= new_len;
  end

  assign rd_frame_ready = !lf_empty;
  assign rd_frame_len   = lf_empty ? 16'd0 : head_len;
  assign rd_data_valid  = rd_vld_q;
  assign rd_data        = rd_word_q.dat;
  assign rd_bytes_valid = rd_word_q.bv;
  assign rd_last        = rd_last_q;
  assign perf_crc_drops = crc_cnt_q;
  assign perf_ovf_drops = ovf_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: directed frames, expected read words queued at send time and
// checked by an independent monitor whenever rd_data_valid is seen.
module tb_eth_rx_frame_buffer;
  localparam int DEPTH = 16;
  localparam int MAXF  = 4;

  logic        clk = 1'b0;
  logic        reset, rx_start, rx_data_valid, rx_commit, rx_drop, rd_pop;
  logic [2:0]  rx_bytes_valid;
  logic [31:0] rx_data;
  logic        rd_frame_ready, rd_data_valid, rd_last;
  logic [15:0] rd_frame_len;
  logic [31:0] rd_data, perf_crc_drops, perf_ovf_drops;
  logic [2:0]  rd_bytes_valid;

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  bv;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  eth_rx_frame_buffer #(.DEPTH(DEPTH), .MAX_FRAMES(MAXF)) dut (
    .clk(clk), .reset(reset),
    .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_bytes_valid(rx_bytes_valid),
    .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .rd_frame_ready(rd_frame_ready), .rd_frame_len(rd_frame_len), .rd_pop(rd_pop),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_bytes_valid(rd_bytes_valid),
    .rd_last(rd_last), .perf_crc_drops(perf_crc_drops), .perf_ovf_drops(perf_ovf_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_word actual=0x%0h required=none", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e.dat);
        check("rd_bytes_valid", {29'b0, rd_bytes_valid}, {29'b0, e.bv});
        check("rd_last", {31'b0, rd_last}, {31'b0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rx_start = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
    rx_bytes_valid = '0; rx_data = '0;
  endtask

  // Byte i of a frame is (seed + i); unused bytes of the last word are zero.
  function automatic logic [31:0] word_of(input int nbytes, input int seed, input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++)
      if (4 * w + b < nbytes) r[31 - 8 * b -: 8] = 8'(seed + 4 * w + b);
    return r;
  endfunction

  function automatic logic [2:0] bv_of(input int nbytes, input int w);
    int n = nbytes - 4 * w;
    return (n >= 4) ? 3'd4 : 3'(n);
  endfunction

  // mode: 0 = commit after data, 1 = commit with last word, 2 = drop, 3 = no end
  task automatic send_frame(input int nbytes, input int seed, input int mode, input bit expect_ok);
    int nw = (nbytes + 3) / 4;
    idle_in();
    rx_start = 1;
    tick();
    rx_start = 0;
    for (int w = 0; w < nw; w++) begin
      rx_data_valid  = 1;
      rx_data        = word_of(nbytes, seed, w);
      rx_bytes_valid = bv_of(nbytes, w);
      rx_commit      = (mode == 1 && w == nw - 1);
      if (expect_ok) exp_q.push_back('{dat: rx_data, bv: rx_bytes_valid, last: (w == nw - 1)});
      tick();
    end
    idle_in();
    if (mode == 0) begin rx_commit = 1; tick(); end
    else if (mode == 2) begin rx_drop = 1; tick(); end
    idle_in();
    tick();
  endtask

  task automatic drain(input string name);
    int budget = 300;
    rd_pop = 1;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    rd_pop = 0;
    tick();
    tick();
    check({name, "_words_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    idle_in();
    rd_pop = 0;
    reset = 1;
    tick();
    tick();
    exp_q.delete();
    reset = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    rd_pop = 0;
    idle_in();
    repeat (3) tick();
    check("rst_ready", rd_frame_ready, 0);
    check("rst_len", rd_frame_len, 0);
    check("rst_valid", rd_data_valid, 0);
    check("rst_crc", perf_crc_drops, 0);
    check("rst_ovf", perf_ovf_drops, 0);
    reset = 0;
    tick();

    rd_pop = 1;
    tick();
    check("pop_empty_valid", rd_data_valid, 0);
    rd_pop = 0;

    send_frame(64, 'h10, 0, 1);
    check("t1_ready", rd_frame_ready, 1);
    check("t1_len", rd_frame_len, 64);
    drain("t1");
    check("t1_ready_after", rd_frame_ready, 0);

    send_frame(61, 'h80, 1, 1);
    check("t2_len", rd_frame_len, 61);
    drain("t2");

    send_frame(0, 0, 0, 0);
    check("zero_len_ready", rd_frame_ready, 0);
    check("zero_len_ovf", perf_ovf_drops, 0);

    send_frame(20, 'hA0, 2, 0);
    send_frame(12, 'h33, 0, 1);
    check("t3_crc", perf_crc_drops, 1);
    check("t3_len", rd_frame_len, 12);
    drain("t3");

    send_frame(100, 'h01, 0, 0);
    check("t4_ready", rd_frame_ready, 0);
    check("t4_ovf", perf_ovf_drops, 1);
    send_frame(32, 'h55, 1, 1);
    check("t4_len", rd_frame_len, 32);
    drain("t4");

    send_frame(8, 'h77, 3, 0);
    send_frame(16, 'h90, 0, 1);
    check("trunc_ovf", perf_ovf_drops, 2);
    check("trunc_len", rd_frame_len, 16);
    drain("trunc");

    send_frame(5, 'h11, 0, 1);
    send_frame(6, 'h22, 1, 1);
    send_frame(7, 'h33, 0, 1);
    send_frame(8, 'h44, 1, 1);
    send_frame(3, 'h55, 0, 0);
    check("t5_ovf", perf_ovf_drops, 3);
    check("t5_len", rd_frame_len, 5);
    drain("t5");
    check("t5_ready_after", rd_frame_ready, 0);

    send_frame(12, 'h21, 3, 0);
    do_reset();
    check("t6_recv_ready", rd_frame_ready, 0);
    check("t6_crc", perf_crc_drops, 0);
    check("t6_ovf", perf_ovf_drops, 0);

    send_frame(40, 'h44, 0, 1);
    check("t6_len40", rd_frame_len, 40);
    rd_pop = 1;
    repeat (3) tick();
    rd_pop = 0;
    tick();
    check("t6_partial_left", exp_q.size(), 7);
    do_reset();
    check("t6_read_ready", rd_frame_ready, 0);
    check("t6_read_valid", rd_data_valid, 0);
    check("t6_read_ovf", perf_ovf_drops, 0);

    send_frame(8, 'hC0, 1, 1);
    check("t6_next_len", rd_frame_len, 8);
    drain("t6_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
